alu_packet_responder: RTL and testbench
=======================================

# alu_packet_responder

FPGA-side packet engine of the UART ALU. Sits between the UART receiver's AXI-Stream byte output and the UART transmitter's AXI-Stream byte input inside the icebreaker top. Parses host command packets, executes echo, 32-bit add or 32-bit multiply, and streams the response bytes back to the host.

## Interface
- DATA_WIDTH_P, 8, stream byte width; only 8 is supported.
- ACC_WIDTH_P, 32, operand/accumulator width; must be a multiple of 8.
- clk  input  1  single clock domain (PLL output).
- rst_n  input  1  reset, asynchronous, active-low.
- s_axis_tdata  input  8  byte from UART receiver.
- s_axis_tvalid  input  1  receive byte valid.
- s_axis_tready  output  1  responder accepts byte.
- m_axis_tdata  output  8  response byte to UART transmitter.
- m_axis_tvalid  output  1  response byte valid.
- m_axis_tready  input  1  transmitter accepts byte.
- busy_o  output  1  high in any state except IDLE.
- error_o  output  1  one-cycle pulse on malformed or unknown packet.

## Operation
- Packet: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]; LEN counts all bytes including the 4-byte header; payload = LEN-4 bytes.
- Opcodes: 0xEC echo, 0xA0 add, 0xA1 mul. Any other opcode is unknown.
- States: IDLE, HDR, ECHO, OPND, RESP, DRAIN.
- IDLE: first accepted byte is latched as opcode -> HDR; header byte counter runs 1..3.
- On the 4th header byte: LEN<4 -> error_o, IDLE. Unknown opcode -> error_o, DRAIN (LEN-4 bytes; LEN=4 goes directly to IDLE). Echo -> ECHO (LEN=4 -> IDLE, no output). Add/mul: LEN-4 zero or not a multiple of 4 -> error_o, DRAIN; otherwise -> OPND.
- ECHO: combinational pass-through. m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready. The remaining count decrements per handshake; -> IDLE after the last byte.
- OPND: bytes are assembled little-endian into a 32-bit operand. On each 4th byte: first operand -> acc = operand; later operands -> acc = acc+operand (add) or acc = low 32 bits of acc*operand (mul). Wrap-around silently truncates to 32 bits. The last operand -> RESP.
- RESP: 4 bytes, acc[7:0] first. Each byte advances on m_axis_tvalid && m_axis_tready. s_axis_tready=0. -> IDLE after the 4th byte.
- DRAIN: accepts and discards bytes until the count reaches zero, -> IDLE. No output.
- s_axis_tready = 1 in IDLE, HDR, OPND, DRAIN. In RESP it is 0.

## Timing
- Reset values (while rst_n=0): all outputs 0, state IDLE, counters and acc 0. s_axis_tready rises combinationally once rst_n=1 in IDLE.
- error_o asserts the cycle after the offending 4th header byte handshake, for exactly 1 cycle.
- Add/mul latency: the first response byte is valid the cycle after the final operand byte handshake. Multiply is single-cycle combinational.
- Echo latency: 0 cycles (same-cycle pass-through).
- Under backpressure, m_axis_tdata and m_axis_tvalid stay stable until the handshake completes.
- Reset mid-packet: everything returns to IDLE immediately. Partial packet and any pending response are discarded. The host is responsible for resynchronisation.
- Throughput: 1 byte/cycle in IDLE, HDR, OPND and DRAIN.

## Configuration
- ALU_MUL_EN defined: opcode 0xA1 is the multiply above.
- ALU_MUL_EN undefined: no multiplier is synthesised. 0xA1 is handled as an unknown opcode (error_o pulse, payload drained, no response).

## Test plan
- Add: A0 00 0C 00 01 00 00 00 02 00 00 00 -> response 03 00 00 00; error_o stays 0.
- Echo: EC 00 07 00 41 42 43 -> output 41 42 43 with zero latency. Then EC 00 04 00 -> no output, busy_o returns low.
- Mul wrap, ALU_MUL_EN defined: A1 00 0C 00 00 00 01 00 00 00 01 00 -> 00 00 00 00. With the macro undefined, the same packet -> one error_o pulse, no output, and the next add packet answers correctly.
- Malformed: 55 00 06 00 AA BB -> error_o pulse, 2 bytes drained, no output. Then A0 00 0A 00 plus 6 bytes -> error_o, drain. A following valid add succeeds.
- Backpressure: during a response to A0 00 08 00 FF FF FF FF, hold m_axis_tready low for 10 cycles per byte -> bytes FF FF FF FF in order, data stable while stalled.
- Reset mid-OPND: assert rst_n=0 after 6 payload bytes -> outputs 0, busy_o 0. A fresh add packet then yields its correct sum.

Source files
------------

// File: rtl/alu_packet_responder.sv
// UART ALU packet engine: parses echo/add/mul command packets from an AXI-Stream byte
// input and streams the response back. Optional feature macro: ALU_MUL_EN (enables opcode 0xA1).
module alu_packet_responder #(
  parameter int DATA_WIDTH_P = 8,
  parameter int ACC_WIDTH_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int NB     = ACC_WIDTH_P / 8;
  localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NB - 1);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;

  typedef enum logic [2:0] {IDLE, HDR, ECHO, OPND, RESP, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               hdr_cnt_q, hdr_cnt_d;
  logic [7:0]               opcode_q, opcode_d;
  logic [7:0]               len_lo_q, len_lo_d;
  logic [15:0]              rem_q, rem_d;
  logic [ACC_WIDTH_P-9:0]   opnd_q, opnd_d;
  logic [BIDX_W-1:0]        bidx_q, bidx_d;
  logic [BIDX_W-1:0]        ridx_q, ridx_d;
  logic                     first_q, first_d;
  logic [ACC_WIDTH_P-1:0]   acc_q, acc_d;
  logic                     error_q, error_d;

  logic [15:0]              len_full;
  logic [15:0]              payload;
  logic [ACC_WIDTH_P-1:0]   operand;
  logic [ACC_WIDTH_P-1:0]   alu_res;
  logic                     op_add, op_mul, op_alu;
  logic                     s_rdy, m_vld;
  logic [DATA_WIDTH_P-1:0]  m_dat;

  // The incoming byte completes the little-endian operand on top of the stored lower bytes.
  assign operand  = {s_axis_tdata, opnd_q};
  assign len_full = {s_axis_tdata, len_lo_q};
  assign payload  = len_full - 16'd4;
  assign op_add   = (opcode_q == OP_ADD);

`ifdef ALU_MUL_EN
  localparam logic [7:0] OP_MUL = 8'hA1;
  assign op_mul  = (opcode_q == OP_MUL);
  assign alu_res = op_mul ? acc_q * operand : acc_q + operand;
`else
  assign op_mul  = 1'b0;
  assign alu_res = acc_q + operand;
`endif

  assign op_alu = op_add | op_mul;

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    opcode_d  = opcode_q;
    len_lo_d  = len_lo_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    bidx_d    = bidx_q;
    ridx_d    = ridx_q;
    first_d   = first_q;
    acc_d     = acc_q;
    error_d   = 1'b0;
    s_rdy     = 1'b0;
    m_vld     = 1'b0;
    m_dat     = '0;
    case (state_q)
      IDLE: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          opcode_d  = s_axis_tdata;
          hdr_cnt_d = 2'd1;
          state_d   = HDR;
        end
      end
      HDR: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd2) len_lo_d = s_axis_tdata;
          if (hdr_cnt_q == 2'd3) begin
            rem_d   = payload;
            bidx_d  = '0;
            first_d = 1'b1;
            if (len_full < 16'd4) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else if (opcode_q == OP_ECHO) begin
              state_d = (payload == 16'd0) ? IDLE : ECHO;
            end else if (op_alu && payload != 16'd0 && payload[1:0] == 2'b00) begin
              state_d = OPND;
            end else begin
              // Unknown opcode or bad operand length: flag it and swallow the payload.
              error_d = 1'b1;
              state_d = (payload == 16'd0) ? IDLE : DRAIN;
            end
          end
        end
      end
      ECHO: begin
        m_dat = s_axis_tdata;
        m_vld = s_axis_tvalid;
        s_rdy = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      OPND: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          opnd_d = operand[ACC_WIDTH_P-1:8];
          bidx_d = bidx_q + 1'b1;
          rem_d  = rem_q - 16'd1;
          if (bidx_q == BIDX_LAST) begin
            first_d = 1'b0;
            acc_d   = first_q ? operand : alu_res;
          end
          if (rem_q == 16'd1) begin
            ridx_d  = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        m_vld = 1'b1;
        m_dat = acc_q[{ridx_q, 3'b000} +: 8];
        if (m_axis_tready) begin
          ridx_d = ridx_q + 1'b1;
          if (ridx_q == BIDX_LAST) state_d = IDLE;
        end
      end
      DRAIN: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_cnt_q <= '0;
      opcode_q  <= '0;
      len_lo_q  <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      bidx_q    <= '0;
      ridx_q    <= '0;
      first_q   <= 1'b0;
      acc_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      opcode_q  <= opcode_d;
      len_lo_q  <= len_lo_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      bidx_q    <= bidx_d;
      ridx_q    <= ridx_d;
      first_q   <= first_d;
      acc_q     <= acc_d;
      error_q   <= error_d;
    end
  end

  // tready is held low while reset is asserted even though IDLE would otherwise accept.
  assign s_axis_tready = s_rdy & rst_n;
  assign m_axis_tvalid = m_vld;
  assign m_axis_tdata  = m_dat;
  assign busy_o        = (state_q != IDLE);
  assign error_o       = error_q;

endmodule

// File: tb/tb_alu_packet_responder.sv
// Randomized self-checking bench for alu_packet_responder with a packet-level reference model.
module tb_alu_packet_responder;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       busy_o;
  logic       error_o;

  alu_packet_responder #(.DATA_WIDTH_P(8), .ACC_WIDTH_P(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int rdy_mode = 0;
  int stall_ctr = 0;
  logic echo_active = 1'b0;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected output bytes and error flag for the packet in pkt_q.
  function automatic void model_pkt();
    logic [7:0] op;
    int len;
    int unsigned acc, word;
    op = pkt_q[0];
    len = {pkt_q[3], pkt_q[2]};
    exp_err = 1'b0;
    acc = 0;
    if (len < 4) exp_err = 1'b1;
    else if (op == 8'hEC) begin
      for (int i = 4; i < len; i++) exp_q.push_back(pkt_q[i]);
    end else if (op == 8'hA0 || (op == 8'hA1 && MUL_EN)) begin
      if (len == 4 || (len - 4) % 4 != 0) exp_err = 1'b1;
      else begin
        for (int w = 0; w < (len - 4) / 4; w++) begin
          word = {pkt_q[4+4*w+3], pkt_q[4+4*w+2], pkt_q[4+4*w+1], pkt_q[4+4*w]};
          if (w == 0) acc = word;
          else if (op == 8'hA0) acc = acc + word;
          else acc = acc * word;
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
      end
    end else exp_err = 1'b1;
  endfunction

  // Inputs change 1 time unit after posedge; handshake decided by tready seen at the negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic hs;
    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    s_axis_tdata = b;
    s_axis_tvalid = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!hs) chk("handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_pkt(input int lit_n, input logic [31:0] lit_w, input logic lit_err);
    int e0, n, len;
    logic is_echo;
    logic [31:0] mw;
    model_pkt();
    if (lit_n >= 0) begin
      chk("model_nbytes", 32'(exp_q.size()), 32'(lit_n));
      chk("model_err", 32'(exp_err), 32'(lit_err));
      mw = 32'd0;
      for (int i = 0; i < exp_q.size() && i < 4; i++) mw[8*i +: 8] = exp_q[i];
      chk("model_word", mw, lit_w);
    end
    len = {pkt_q[3], pkt_q[2]};
    is_echo = (pkt_q[0] == 8'hEC) && (len > 4);
    e0 = err_seen;
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(pkt_q[i]);
      if (i == 3) begin
        chk("err_timing", 32'(error_o), 32'(exp_err));
        if (is_echo) echo_active = 1'b1;
      end
      if (i == pkt_q.size() - 1) begin
        echo_active = 1'b0;
        if (!is_echo && exp_q.size() != 0) chk("resp_latency", 32'(m_axis_tvalid), 32'd1);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("busy_end", 32'(busy_o), 32'd0);
    chk("err_count", 32'(err_seen - e0), 32'(exp_err));
  endtask

  task automatic gen_random();
    int sel, plen, len;
    logic [7:0] op;
    sel = $urandom_range(0, 9);
    if (sel <= 2) begin op = 8'hEC; plen = $urandom_range(0, 6); end
    else if (sel <= 7) begin
      op = (sel <= 5) ? 8'hA0 : 8'hA1;
      plen = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 4 * $urandom_range(1, 3);
    end else begin
      op = 8'(($urandom_range(0, 3) == 0) ? 32'hEC : $urandom_range(0, 255));
      if (sel == 8) while (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = 8'($urandom_range(0, 255));
      plen = (sel == 8) ? $urandom_range(0, 5) : 0;
    end
    len = (sel == 9) ? $urandom_range(0, 3) : plen + 4;
    pkt_q.delete();
    pkt_q.push_back(op);
    pkt_q.push_back(8'($urandom_range(0, 255)));
    pkt_q.push_back(8'(len));
    pkt_q.push_back(8'(len >> 8));
    for (int i = 0; i < plen && sel != 9; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'($urandom_range(0, 1));
      default: begin
        stall_ctr = (stall_ctr == 10) ? 0 : stall_ctr + 1;
        m_axis_tready = (stall_ctr == 10);
      end
    endcase
  end

  logic prev_stall = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'(m_axis_tvalid), 32'd0);
        else chk("out_byte", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", 32'(m_axis_tdata), 32'(prev_d));
      end
      if (echo_active) begin
        chk("echo_valid", 32'(m_axis_tvalid), 32'(s_axis_tvalid));
        if (s_axis_tvalid) chk("echo_data", 32'(m_axis_tdata), 32'(s_axis_tdata));
      end else if (m_axis_tvalid) chk("resp_no_accept", 32'(s_axis_tready), 32'd0);
      if (error_o) begin
        err_seen++;
        chk("err_one_cycle", 32'(prev_err), 32'd0);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_err = error_o;
    end else begin
      prev_stall = 1'b0;
      prev_err = 1'b0;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    #1;
    chk("tready_after_reset", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #1;

    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(4, 32'h00000003, 1'b0);
    pkt_q = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt(3, 32'h00434241, 1'b0);
    pkt_q = {8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt(0, 32'h0, 1'b0);
    pkt_q = {8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    if (MUL_EN) send_pkt(4, 32'h00000000, 1'b0);
    else send_pkt(0, 32'h0, 1'b1);
    pkt_q = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt(4, 32'h00000005, 1'b0);
    pkt_q = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt(0, 32'h0, 1'b1);
    pkt_q = {8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(0, 32'h0, 1'b1);
    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(4, 32'h00000001, 1'b0);

    rdy_mode = 2;
    pkt_q = {8'hA0, 8'h00, 8'h08, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt(4, 32'hFFFFFFFF, 1'b0);
    rdy_mode = 0;

    // Reset in the middle of an operand stream.
    pkt_q = {8'hA0, 8'h00, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i]);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_q = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    send_pkt(4, 32'h00000030, 1'b0);

    for (int k = 0; k < 60; k++) begin
      rdy_mode = $urandom_range(0, 1);
      gen_random();
      send_pkt(-1, 32'h0, 1'b0);
    end
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
